// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared definitions for the write-back trap sequencer: FSM encoding,
// default exception vector and the layout of the bundled CP0 take bus.
package exc_redirect_ctrl_pkg;

    localparam logic [31:0] EXC_VEC_DEFAULT = 32'hbfc00380;

    // One bit per CP0 take pulse; exactly one is set in an event cycle.
    localparam int EXC_CTRL_BUS_WD = 3;
    localparam int TAKE_INT        = 2;
    localparam int TAKE_EXC        = 1;
    localparam int TAKE_ERET       = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_t;

endpackage

// File: rtl/exc_redirect_ctrl.sv
// Trap sequencer at the write-back boundary: flushes the pipeline, pulses
// the CP0 take lines and holds a PC redirect until pre-IF accepts it.
module exc_redirect_ctrl
    import exc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC      = EXC_VEC_DEFAULT,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    input  logic        ws_exc_sys,
    input  logic        ws_eret,
    input  logic [31:0] ws_pc,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_int_pending,
    output logic        flush,
    output logic        cp0_int_take,
    output logic        cp0_exc_take,
    output logic        cp0_eret_take,
    output logic        fetch_hold,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
            $error("exc_redirect_ctrl: FLUSH_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    exc_state_t                 state;
    logic [3:0]                 flush_cnt;
    logic                       event_hit;
    logic [EXC_CTRL_BUS_WD-1:0] take_bus;

    // ws_pc is consumed by CP0 directly (EPC<=ws_pc on a take pulse).
    logic unused_ws_pc;
    assign unused_ws_pc = ^ws_pc;

    assign event_hit = !reset && (state == ST_IDLE) && ws_valid
                       && (cp0_int_pending || ws_exc_sys || ws_eret);

    // Priority: interrupt over SYSCALL over ERET.
    always_comb begin
        take_bus = '0;
        if (event_hit) begin
            if (cp0_int_pending)  take_bus[TAKE_INT]  = 1'b1;
            else if (ws_exc_sys)  take_bus[TAKE_EXC]  = 1'b1;
            else                  take_bus[TAKE_ERET] = 1'b1;
        end
    end

    assign cp0_int_take  = take_bus[TAKE_INT];
    assign cp0_exc_take  = take_bus[TAKE_EXC];
    assign cp0_eret_take = take_bus[TAKE_ERET];
    assign flush         = event_hit || (state == ST_FLUSH);
    assign busy          = (state != ST_IDLE);
    assign dbg_state     = state;

    // Redirect handshake: redirect_valid stays high with redirect_pc stable
    // until a cycle where redirect_ready is also high; that cycle is the
    // transfer. redirect_ready while redirect_valid is low is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            flush_cnt      <= 4'd0;
            redirect_pc    <= 32'd0;
            fetch_hold     <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (event_hit) begin
                        redirect_pc <= take_bus[TAKE_ERET] ? cp0_epc : EXC_VEC;
                        fetch_hold  <= 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FLUSH_INIT;
                        end else begin
                            state          <= ST_REDIRECT;
                            redirect_valid <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt - 4'd1;
                    if (flush_cnt == 4'd1) begin
                        state          <= ST_REDIRECT;
                        redirect_valid <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= ST_IDLE;
                        redirect_valid <= 1'b0;
                        fetch_hold     <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    redirect_valid <= 1'b0;
                    fetch_hold     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Bench for exc_redirect_ctrl: two instances (FLUSH_CYCLES=1 and 3) share
// stimulus and are compared each cycle against a cycles-since-event model.
module tb_exc_redirect_ctrl;

    localparam logic [31:0] VEC = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ws_valid = 1'b0;
    logic        ws_exc_sys = 1'b0;
    logic        ws_eret = 1'b0;
    logic [31:0] ws_pc = 32'd0;
    logic [31:0] cp0_epc = 32'd0;
    logic        cp0_int_pending = 1'b0;
    logic        redirect_ready = 1'b0;

    logic        d_flush [2];
    logic        d_int [2];
    logic        d_exc [2];
    logic        d_eret [2];
    logic        d_hold [2];
    logic        d_rv [2];
    logic [31:0] d_pc [2];
    logic        d_busy [2];
    logic [1:0]  d_state [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per instance, whether a trap is in progress, how many
    // cycles have elapsed since its event cycle, and the fetch target.
    int          fc [2] = '{1, 3};
    bit          m_active [2];
    int          m_age [2];
    logic [31:0] m_target [2];

    always #5 clk = ~clk;

    exc_redirect_ctrl #(.EXC_VEC(VEC), .FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_exc_sys(ws_exc_sys),
        .ws_eret(ws_eret), .ws_pc(ws_pc), .cp0_epc(cp0_epc),
        .cp0_int_pending(cp0_int_pending), .flush(d_flush[0]),
        .cp0_int_take(d_int[0]), .cp0_exc_take(d_exc[0]), .cp0_eret_take(d_eret[0]),
        .fetch_hold(d_hold[0]), .redirect_valid(d_rv[0]), .redirect_pc(d_pc[0]),
        .redirect_ready(redirect_ready), .busy(d_busy[0]), .dbg_state(d_state[0])
    );

    exc_redirect_ctrl #(.EXC_VEC(VEC), .FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_exc_sys(ws_exc_sys),
        .ws_eret(ws_eret), .ws_pc(ws_pc), .cp0_epc(cp0_epc),
        .cp0_int_pending(cp0_int_pending), .flush(d_flush[1]),
        .cp0_int_take(d_int[1]), .cp0_exc_take(d_exc[1]), .cp0_eret_take(d_eret[1]),
        .fetch_hold(d_hold[1]), .redirect_valid(d_rv[1]), .redirect_pc(d_pc[1]),
        .redirect_ready(redirect_ready), .busy(d_busy[1]), .dbg_state(d_state[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] obs_flags(input int k);
        return {d_flush[k], d_int[k], d_exc[k], d_eret[k], d_hold[k], d_rv[k], d_busy[k]};
    endfunction

    // Expected {flush, int_take, exc_take, eret_take, fetch_hold, redirect_valid, busy}.
    function automatic logic [6:0] exp_flags(input int k);
        logic ev;
        ev = !reset && ws_valid && (cp0_int_pending || ws_exc_sys || ws_eret);
        if (!m_active[k])
            return {ev, ev && cp0_int_pending, ev && !cp0_int_pending && ws_exc_sys,
                    ev && !cp0_int_pending && !ws_exc_sys && ws_eret, 1'b0, 1'b0, 1'b0};
        if (m_age[k] < fc[k])
            return 7'b1000101;
        return 7'b0000111;
    endfunction

    task automatic model_step(input int k);
        logic ev;
        ev = ws_valid && (cp0_int_pending || ws_exc_sys || ws_eret);
        if (reset) begin
            m_active[k] = 1'b0;
            m_target[k] = 32'd0;
        end else if (!m_active[k]) begin
            if (ev) begin
                m_active[k] = 1'b1;
                m_age[k]    = 1;
                m_target[k] = (!cp0_int_pending && !ws_exc_sys) ? cp0_epc : VEC;
            end
        end else if (m_age[k] >= fc[k] && redirect_ready) begin
            m_active[k] = 1'b0;
        end else begin
            m_age[k] = m_age[k] + 1;
        end
    endtask

    task automatic drive(input logic v, input logic sys, input logic er, input logic irq,
                         input logic [31:0] pc, input logic [31:0] epc,
                         input logic rdy, input logic rst);
        @(negedge clk);
        ws_valid = v; ws_exc_sys = sys; ws_eret = er; cp0_int_pending = irq;
        ws_pc = pc; cp0_epc = epc; redirect_ready = rdy; reset = rst;
        #1;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check(k == 0 ? "u1_flags" : "u3_flags", 64'(obs_flags(k)), 64'(exp_flags(k)));
            check(k == 0 ? "u1_redirect_pc" : "u3_redirect_pc", 64'(d_pc[k]), 64'(m_target[k]));
            check(k == 0 ? "u1_dbg_busy" : "u3_dbg_busy", 64'(d_state[k] != 2'd0), 64'(m_active[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
    endtask

    task automatic cycle(input logic v, input logic sys, input logic er, input logic irq,
                         input logic [31:0] pc, input logic [31:0] epc,
                         input logic rdy, input logic rst);
        drive(v, sys, er, irq, pc, epc, rdy, rst);
        compare_all();
        tick();
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'd0, 32'd0, rdy, 0);
    endtask

    initial begin
        int flush_cnt3;
        int take_cnt3;
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0; m_age[k] = 0; m_target[k] = 32'd0;
        end

        // Reset, then idle state with everything low.
        repeat (2) @(posedge clk);
        drive(0, 0, 0, 0, 32'd0, 32'd0, 0, 0);
        check("reset_u1_flags", 64'(obs_flags(0)), 64'd0);
        check("reset_u3_pc", 64'(d_pc[1]), 64'd0);
        compare_all();
        tick();

        // SYSCALL: same-cycle flush/take, redirect to the vector next cycle.
        drive(1, 1, 0, 0, 32'hbfc00100, 32'd0, 0, 0);
        check("sys_flush", 64'(d_flush[0]), 64'd1);
        check("sys_exc_take", 64'(d_exc[0]), 64'd1);
        compare_all();
        tick();
        drive(0, 0, 0, 0, 32'd0, 32'd0, 1, 0);
        check("sys_redirect_valid", 64'(d_rv[0]), 64'd1);
        check("sys_redirect_pc", 64'(d_pc[0]), 64'(VEC));
        compare_all();
        tick();
        idle_cycles(4, 1);
        check("sys_back_idle", 64'(d_busy[0]), 64'd0);

        // ERET: target is EPC, redirect held through 3 cycles of ready=0.
        drive(1, 0, 1, 0, 32'h0, 32'hbfc00104, 0, 0);
        check("eret_take", 64'(d_eret[0]), 64'd1);
        compare_all();
        tick();
        idle_cycles(3, 0);
        drive(0, 0, 0, 0, 32'd0, 32'd0, 1, 0);
        check("eret_held_valid", 64'(d_rv[0]), 64'd1);
        check("eret_redirect_pc", 64'(d_pc[0]), 64'hbfc00104);
        compare_all();
        tick();
        idle_cycles(2, 1);

        // Interrupt outranks ERET.
        drive(1, 0, 1, 1, 32'h00400010, 32'h12345678, 0, 0);
        check("prio_int_take", 64'(d_int[0]), 64'd1);
        check("prio_eret_take", 64'(d_eret[0]), 64'd0);
        compare_all();
        tick();
        drive(0, 0, 0, 0, 32'd0, 32'd0, 0, 0);
        check("prio_redirect_pc", 64'(d_pc[0]), 64'(VEC));
        compare_all();
        tick();
        idle_cycles(4, 1);

        // FLUSH_CYCLES=3: three flush cycles, SYSCALLs during the trap ignored.
        flush_cnt3 = 0;
        take_cnt3  = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 0, 0, 32'h00400020, 32'd0, 0, 0);
            flush_cnt3 += int'(d_flush[1]);
            take_cnt3  += int'(d_exc[1]) + int'(d_int[1]) + int'(d_eret[1]);
            compare_all();
            tick();
        end
        check("fc3_flush_cycles", 64'(flush_cnt3), 64'd3);
        check("fc3_single_take", 64'(take_cnt3), 64'd1);
        check("fc3_redirect_valid", 64'(d_rv[1]), 64'd1);
        idle_cycles(2, 1);

        // Reset while in REDIRECT aborts the sequence; a new SYSCALL works.
        cycle(1, 1, 0, 0, 32'h00400030, 32'd0, 0, 0);
        idle_cycles(4, 0);
        cycle(0, 0, 0, 0, 32'd0, 32'd0, 0, 1);
        drive(0, 0, 0, 0, 32'd0, 32'd0, 0, 0);
        check("rst_u1_flags", 64'(obs_flags(0)), 64'd0);
        check("rst_u3_flags", 64'(obs_flags(1)), 64'd0);
        check("rst_u3_pc", 64'(d_pc[1]), 64'd0);
        compare_all();
        tick();
        drive(1, 1, 0, 0, 32'h00400040, 32'd0, 0, 0);
        check("post_rst_exc_take", 64'(d_exc[1]), 64'd1);
        compare_all();
        tick();
        idle_cycles(5, 1);

        // Interrupt pending but no valid WB instruction: nothing happens.
        drive(0, 0, 0, 1, 32'h00400050, 32'd0, 0, 0);
        check("noev_flags", 64'(obs_flags(0)), 64'd0);
        compare_all();
        tick();
        drive(0, 0, 0, 1, 32'h00400050, 32'd0, 1, 0);
        check("noev_busy", 64'(d_busy[1]), 64'd0);
        compare_all();
        tick();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
